// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the i8080 CPU and a DMA master and generates cpu_ce.
// Optional stall statistics counter enabled by defining ARB_STALL_STATS_EN.
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int DMA_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  cpu_ce,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_rd,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {
        CPU_A,
        CPU_B,
        DMA_A,
        DMA_B
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

    state_t     state, state_nx;
    logic [3:0] burst_cnt, burst_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CPU_A;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        burst_nx  = burst_cnt;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            CPU_A: begin
                mem_rd   = cpu_rd;
                state_nx = CPU_B;
            end
            CPU_B: begin
                mem_we   = cpu_we;
                burst_nx = 4'd0;
                state_nx = dma_req ? DMA_A : CPU_A;
            end
            DMA_A: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_rd    = ~dma_we;
                mem_we    = dma_we;
                burst_nx  = burst_cnt + 4'd1;
                state_nx  = DMA_B;
            end
            DMA_B: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                // burst_cnt already includes the access that just finished
                if (dma_req && (burst_cnt < BURST_MAX)) state_nx = DMA_A;
                else                                    state_nx = CPU_A;
            end
            default: state_nx = CPU_A;
        endcase
    end

    assign cpu_ce    = (state == CPU_B);
    assign dma_gnt   = (state == DMA_A) || (state == DMA_B);
    assign dma_ack   = (state == DMA_B);
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

`ifdef ARB_STALL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 16'h0000;
        end else if (dma_gnt && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: slot-level model plus directed scenarios.
// Honours ARB_STALL_STATS_EN for the stall counter expectation.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_ce;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_rd = 1'b0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req = 1'b0;
    logic          dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          dma_gnt;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DMA_BURST (BURST)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_ce   (cpu_ce),
        .cpu_addr (cpu_addr),
        .cpu_rd   (cpu_rd),
        .cpu_we   (cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_gnt  (dma_gnt),
        .dma_ack  (dma_ack),
        .dma_rdata(dma_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rd   (mem_rd),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    // RAM behind the arbiter
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rdq = '0;
    assign mem_rdata = rdq;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_rd) rdq <= ram[mem_addr];
    end

    // Model: who owns the RAM, which half of the slot, accesses since last CPU slot
    bit            m_dma = 1'b0;
    bit            m_half = 1'b0;
    int            m_acc = 0;
    int            m_stall = 0;
    bit            m_rv = 1'b0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    function automatic bit e_rd();
        if (m_half) return 1'b0;
        return m_dma ? !dma_we : cpu_rd;
    endfunction

    function automatic bit e_we();
        return m_dma ? (!m_half && dma_we) : (m_half && cpu_we);
    endfunction

    function automatic logic [AW-1:0] e_addr();
        return m_dma ? dma_addr : cpu_addr;
    endfunction

    function automatic logic [DW-1:0] e_wdata();
        return m_dma ? dma_wdata : cpu_wdata;
    endfunction

    function automatic int e_stall();
`ifdef ARB_STALL_STATS_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dma = 1'b0;
            m_half = 1'b0;
            m_acc = 0;
            m_stall = 0;
            m_rv = 1'b0;
        end else begin
            m_rv = e_rd();
            if (m_rv) m_rd = shadow[e_addr()];
            if (e_we()) shadow[e_addr()] = e_wdata();
            if (m_dma && m_stall < 65535) m_stall++;
            if (!m_half) begin
                if (m_dma) m_acc++;
                m_half = 1'b1;
            end else if (!m_dma) begin
                m_acc = 0;
                m_dma = dma_req;
                m_half = 1'b0;
            end else begin
                m_dma = dma_req && (m_acc < BURST);
                m_half = 1'b0;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Scenario counters, cleared by the stimulus
    int ce_n, gnt_n, ack_n, we3ff_n, run, max_run;

    task automatic clr();
        ce_n = 0; gnt_n = 0; ack_n = 0; we3ff_n = 0; run = 0; max_run = 0;
    endtask

    always @(negedge clk) begin
        chk("cpu_ce", 32'(cpu_ce), 32'(!m_dma && m_half));
        chk("dma_gnt", 32'(dma_gnt), 32'(m_dma));
        chk("dma_ack", 32'(dma_ack), 32'(m_dma && m_half));
        chk("mem_rd", 32'(mem_rd), 32'(e_rd()));
        chk("mem_we", 32'(mem_we), 32'(e_we()));
        if (e_rd() || e_we()) chk("mem_addr", 32'(mem_addr), 32'(e_addr()));
        if (e_we()) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata()));
        if (!m_dma && m_half && m_rv) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rd));
        if (m_dma && m_half && m_rv) chk("dma_rdata", 32'(dma_rdata), 32'(m_rd));
        chk("stall_cnt", 32'(stall_cnt), 32'(e_stall()));
        if (cpu_ce) begin ce_n++; run = 0; end
        if (dma_gnt) gnt_n++;
        if (dma_ack) begin
            ack_n++;
            run++;
            if (run > max_run) max_run = run;
        end
        if (mem_we && mem_addr == 10'h3FF) we3ff_n++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cpu_a();
        for (int i = 0; i < 12 && (cpu_ce || dma_gnt); i++) step(1);
        chk("reach_cpu_a", 32'(cpu_ce || dma_gnt), 32'd0);
    endtask

    task automatic dma_access(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, output logic [DW-1:0] rd);
        int lat;
        dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
        step(1);
        lat = 1;
        for (int i = 0; i < 12 && !dma_ack; i++) begin
            step(1);
            lat++;
        end
        chk("dma_ack_seen", 32'(dma_ack), 32'd1);
        chk("dma_latency_le4", 32'(lat <= 4), 32'd1);
        rd = dma_rdata;
        dma_req = 1'b0;
    endtask

    logic [DW-1:0] rd;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        ram[5] = 8'hA5;
        shadow[5] = 8'hA5;
        clr();
        step(3);
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        reset_n = 1'b1;
        step(1);

        // three DMA writes -> six stalled cycles
        dma_access(1'b1, 10'h100, 8'h11, rd);
        dma_access(1'b1, 10'h101, 8'h22, rd);
        dma_access(1'b1, 10'h102, 8'h33, rd);
        step(2);
`ifdef ARB_STALL_STATS_EN
        chk("stall_after_3", 32'(stall_cnt), 32'd6);
`else
        chk("stall_after_3", 32'(stall_cnt), 32'd0);
`endif

        // CPU only: ce every second clock, read data A5
        cpu_addr = 10'h005; cpu_rd = 1'b1;
        step(1);
        clr();
        step(8);
        chk("t1_ce_count", 32'(ce_n), 32'd4);
        chk("t1_gnt_count", 32'(gnt_n), 32'd0);
        for (int i = 0; i < 4 && !cpu_ce; i++) step(1);
        chk("t1_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        cpu_rd = 1'b0;

        // DMA write to 3FF alongside CPU writes
        wait_cpu_a();
        cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wdata = 8'h4E;
        clr();
        dma_access(1'b1, 10'h3FF, 8'h3C, rd);
        step(2);
        cpu_we = 1'b0;
        chk("t2_gnt_cycles", 32'(gnt_n), 32'd2);
        chk("t2_ack_count", 32'(ack_n), 32'd1);
        chk("t2_we_3ff", 32'(we3ff_n), 32'd1);
        chk("t2_ram_3ff", 32'(ram[10'h3FF]), 32'h3C);
        chk("t2_cpu_write", 32'(ram[10'h010]), 32'h4E);

        // CPU writes 77 to 001, DMA reads it back
        cpu_addr = 10'h001; cpu_wdata = 8'h77; cpu_we = 1'b1;
        for (int i = 0; i < 6 && !cpu_ce; i++) step(1);
        step(1);
        cpu_we = 1'b0;
        dma_access(1'b0, 10'h001, 8'h00, rd);
        chk("t4_dma_rdata", 32'(rd), 32'h77);

        // held request: bursts of four, one CPU slot between
        wait_cpu_a();
        dma_we = 1'b1; dma_addr = 10'h020; dma_wdata = 8'h5A; dma_req = 1'b1;
        clr();
        step(22);
        dma_req = 1'b0;
        chk("t3_ack_count", 32'(ack_n), 32'd8);
        chk("t3_ce_count", 32'(ce_n), 32'd3);
        chk("t3_max_burst", 32'(max_run), 32'd4);
        clr();
        step(3);
        chk("t3_drop_in_dma_a_ack", 32'(ack_n), 32'd1);

        // reset during DMA_A aborts the access
        wait_cpu_a();
        dma_we = 1'b1; dma_addr = 10'h3FE; dma_wdata = 8'h99; dma_req = 1'b1;
        for (int i = 0; i < 6 && !(dma_gnt && !dma_ack); i++) step(1);
        chk("t5_in_dma_a", 32'(dma_gnt && !dma_ack), 32'd1);
        #1 reset_n = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("t5_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("t5_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("t5_dma_ack", 32'(dma_ack), 32'd0);
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_mem_rd", 32'(mem_rd), 32'd0);
        chk("t5_stall", 32'(stall_cnt), 32'd0);
        clr();
        step(2);
        reset_n = 1'b1;
        step(4);
        chk("t5_no_ack", 32'(ack_n), 32'd0);
        chk("t5_no_write", 32'(ram[10'h3FE]), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
